// File: rtl/counter_pkg.sv
// Shared definitions for the multi-channel step counter: width helper and mode encodings.
package counter_pkg;

    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int ceil_log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/step_counter_ch.sv
// One channel of the step counter: up/down by INCR over 0..(COUNT-1)*INCR,
// saturate or wrap, parallel load, registered terminal-count and wrap pulses.
module step_counter_ch
    import counter_pkg::*;
#(
    parameter int W     = 4,
    parameter int COUNT = 4,
    parameter int INCR  = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_en_i,
    input  logic [W-1:0] load_val_i,
    input  logic         incr_i,
    input  logic         decr_i,
    input  logic         wrap_en_i,
    output logic [W-1:0] count_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         tc_pulse_o,
    output logic         wrap_pulse_o
);

    // One guard bit so sums past MAX are compared before any truncation.
    typedef logic [W:0] ext_t;

    localparam ext_t MAX_X  = ext_t'((COUNT - 1) * INCR);
    localparam ext_t INCR_X = ext_t'(INCR);
    localparam ext_t LAP_X  = ext_t'(COUNT * INCR);

    logic [W-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic         wrap_q, wrap_d;

    ext_t cnt_x, up_x, load_x, next_x;
    logic wrapped;

    always_comb begin
        cnt_x   = {1'b0, count_q};
        up_x    = cnt_x + INCR_X;
        load_x  = {1'b0, load_val_i};
        next_x  = cnt_x;
        wrapped = 1'b0;

        if (clr_i) begin
            next_x = '0;
        end else if (load_en_i) begin
            next_x = (load_x > MAX_X) ? MAX_X : load_x;
        end else if (incr_i && decr_i) begin
            next_x = cnt_x;
        end else if (incr_i) begin
            if (up_x <= MAX_X) begin
                next_x = up_x;
            end else if (wrap_en_i == MODE_WRAP) begin
                wrapped = 1'b1;
                // A full lap (count was MAX) lands on 0; a partial lap from an
                // off-grid loaded value re-enters at its overshoot past MAX.
                next_x  = (up_x >= LAP_X) ? (up_x - LAP_X) : (up_x - MAX_X);
            end else begin
                next_x = MAX_X;
            end
        end else if (decr_i) begin
            if (cnt_x >= INCR_X) begin
                next_x = cnt_x - INCR_X;
            end else if (wrap_en_i == MODE_WRAP) begin
                wrapped = 1'b1;
                next_x  = (cnt_x == '0) ? MAX_X : (cnt_x + MAX_X - INCR_X);
            end else begin
                next_x = '0;
            end
        end
    end

    assign count_d = next_x[W-1:0];
    assign tc_d    = (next_x == MAX_X) && (cnt_x != MAX_X);
    assign wrap_d  = wrapped;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o      = count_q;
    assign full_o       = ({1'b0, count_q} == MAX_X);
    assign empty_o      = (count_q == '0);
    assign tc_pulse_o   = tc_q;
    assign wrap_pulse_o = wrap_q;

endmodule

// File: rtl/counter_multi_sat_updn.sv
// NUM_CH independent step counters sharing one clock; flat buses sliced per channel.
module counter_multi_sat_updn
    import counter_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  COUNT  = 40,
    parameter int  INCR   = 60,
    localparam int W      = ceil_log2((COUNT - 1) * INCR + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   ch_clr,
    input  logic [NUM_CH-1:0]   load_en,
    input  logic [NUM_CH*W-1:0] load_val,
    input  logic [NUM_CH-1:0]   incr,
    input  logic [NUM_CH-1:0]   decr,
    input  logic [NUM_CH-1:0]   wrap_en,
    output logic [NUM_CH*W-1:0] count,
    output logic [NUM_CH-1:0]   full,
    output logic [NUM_CH-1:0]   empty,
    output logic [NUM_CH-1:0]   tc_pulse,
    output logic [NUM_CH-1:0]   wrap_pulse,
    output logic                any_full
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        step_counter_ch #(
            .W     (W),
            .COUNT (COUNT),
            .INCR  (INCR)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .clr_i        (ch_clr[i]),
            .load_en_i    (load_en[i]),
            .load_val_i   (load_val[i*W +: W]),
            .incr_i       (incr[i]),
            .decr_i       (decr[i]),
            .wrap_en_i    (wrap_en[i]),
            .count_o      (count[i*W +: W]),
            .full_o       (full[i]),
            .empty_o      (empty[i]),
            .tc_pulse_o   (tc_pulse[i]),
            .wrap_pulse_o (wrap_pulse[i])
        );
    end

    assign any_full = |full;

endmodule

// File: tb/tb_counter_multi_sat_updn.sv
// Directed vector bench for counter_multi_sat_updn with COUNT=4, INCR=3 (MAX=9, W=4), two channels.
module tb_counter_multi_sat_updn;

    localparam int NUM_CH = 2;
    localparam int COUNT  = 4;
    localparam int INCR   = 3;
    localparam int W      = 4;
    localparam logic [3:0] MAXV = 4'd9;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ch_clr, load_en, incr, decr, wrap_en;
    logic [7:0] load_val;
    logic [7:0] count;
    logic [1:0] full, empty, tc_pulse, wrap_pulse;
    logic       any_full;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    counter_multi_sat_updn #(.NUM_CH(NUM_CH), .COUNT(COUNT), .INCR(INCR)) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_clr     (ch_clr),
        .load_en    (load_en),
        .load_val   (load_val),
        .incr       (incr),
        .decr       (decr),
        .wrap_en    (wrap_en),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .tc_pulse   (tc_pulse),
        .wrap_pulse (wrap_pulse),
        .any_full   (any_full)
    );

    typedef struct {
        logic       rst;
        logic [1:0] clr;
        logic [1:0] ld;
        logic [7:0] lv;
        logic [1:0] inc;
        logic [1:0] dec;
        logic [1:0] wr;
        logic [7:0] cnt;
        logic [1:0] tc;
        logic [1:0] wp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t row(input logic r, input logic [1:0] clr, input logic [1:0] ld,
                                 input logic [7:0] lv, input logic [1:0] inc, input logic [1:0] dec,
                                 input logic [1:0] wr, input logic [7:0] cnt, input logic [1:0] tc,
                                 input logic [1:0] wp);
        vec_t v;
        v.rst = r; v.clr = clr; v.ld = ld; v.lv = lv; v.inc = inc; v.dec = dec;
        v.wr = wr; v.cnt = cnt; v.tc = tc; v.wp = wp;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then compare everything one step after the edge.
    task automatic apply(input vec_t v, input int idx);
        logic [1:0] exp_full, exp_empty;
        rst      = v.rst;
        ch_clr   = v.clr;
        load_en  = v.ld;
        load_val = v.lv;
        incr     = v.inc;
        decr     = v.dec;
        wrap_en  = v.wr;
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_full[c]  = (v.cnt[c*W +: W] == MAXV);
            exp_empty[c] = (v.cnt[c*W +: W] == 4'd0);
        end
        check("count",      idx, count,               v.cnt);
        check("tc_pulse",   idx, {6'd0, tc_pulse},    {6'd0, v.tc});
        check("wrap_pulse", idx, {6'd0, wrap_pulse},  {6'd0, v.wp});
        check("full",       idx, {6'd0, full},        {6'd0, exp_full});
        check("empty",      idx, {6'd0, empty},       {6'd0, exp_empty});
        check("any_full",   idx, {7'd0, any_full},    {7'd0, |exp_full});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int step;
        // reset with every input high
        vq.push_back(row(0, 2'b11, 2'b11, 8'hFF, 2'b11, 2'b11, 2'b11, 8'h00, 2'b00, 2'b00));
        vq.push_back(row(0, 2'b11, 2'b11, 8'hFF, 2'b11, 2'b11, 2'b11, 8'h00, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00));
        // saturate ch0 up then down
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 2'b00, 8'h06, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 2'b00, 8'h09, 2'b01, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 2'b00, 8'h09, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b01, 2'b00, 8'h06, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b01, 2'b00, 8'h03, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b01, 2'b00, 8'h00, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b01, 2'b00, 8'h00, 2'b00, 2'b00));
        // wrap ch1: load MAX, incr wraps to 0, decr wraps back to MAX
        vq.push_back(row(1, 2'b00, 2'b10, 8'h90, 2'b00, 2'b00, 2'b10, 8'h90, 2'b10, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b10, 2'b00, 2'b10, 8'h00, 2'b00, 2'b10));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 2'b10, 8'h00, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b10, 2'b10, 8'h90, 2'b10, 2'b10));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 2'b10, 8'h90, 2'b00, 2'b00));
        // loads on ch0
        vq.push_back(row(1, 2'b00, 2'b01, 8'h07, 2'b00, 2'b00, 2'b00, 8'h97, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 2'b00, 8'h99, 2'b01, 2'b00));
        vq.push_back(row(1, 2'b01, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 8'h90, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b01, 8'h0F, 2'b00, 2'b00, 2'b00, 8'h99, 2'b01, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b01, 8'h07, 2'b00, 2'b00, 2'b01, 8'h97, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 2'b01, 8'h91, 2'b00, 2'b01));
        // priority and independence
        vq.push_back(row(1, 2'b01, 2'b01, 8'h05, 2'b01, 2'b00, 2'b00, 8'h90, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b01, 8'h05, 2'b01, 2'b00, 2'b00, 8'h95, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b01, 2'b00, 8'h95, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b10, 2'b00, 8'h00, 2'b01, 2'b00, 2'b00, 8'h08, 2'b00, 2'b00));
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b11, 2'b00, 2'b00, 8'h39, 2'b01, 2'b00));
        // mode switch at MAX: wrap applies immediately
        vq.push_back(row(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 2'b01, 8'h30, 2'b00, 2'b01));

        step = 0;
        foreach (vq[k]) begin
            apply(vq[k], step);
            step++;
        end

        // reset mid-count with a wrap and a tc both pending
        apply(row(1, 2'b11, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00), step++);
        apply(row(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00), step++);
        apply(row(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 2'b00, 8'h06, 2'b00, 2'b00), step++);
        apply(row(1, 2'b00, 2'b10, 8'h90, 2'b00, 2'b00, 2'b00, 8'h96, 2'b10, 2'b00), step++);
        apply(row(0, 2'b00, 2'b00, 8'h00, 2'b11, 2'b00, 2'b11, 8'h00, 2'b00, 2'b00), step++);
        apply(row(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 2'b11, 8'h03, 2'b00, 2'b00), step++);
        apply(row(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 2'b11, 8'h06, 2'b00, 2'b00), step++);

        // saturated hold at MAX never re-fires tc across several cycles
        apply(row(1, 2'b00, 2'b01, 8'h09, 2'b00, 2'b00, 2'b00, 8'h09, 2'b01, 2'b00), step++);
        for (int k = 0; k < 3; k++)
            apply(row(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 2'b00, 8'h09, 2'b00, 2'b00), step++);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
